// File: rtl/tilt_shade_scheduler_pkg.sv
// Shared constants, FSM encoding and gray-level helper for the tilt shade quantizer.
// shade_of() is also used by the pitch/roll color blocks.
package tilt_shade_scheduler_pkg;

  localparam int NUM_BUCKETS    = 8;
  localparam int DEF_MAX_Z      = 300;
  localparam int DEF_SHADE_STEP = 25;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Bucket 0 is pure white; every higher bucket darkens by one step from 250.
  function automatic logic [7:0] shade_of(input logic [2:0] bucket, input int step);
    int lvl;
    if (bucket == 3'd0) lvl = 255;
    else                lvl = 250 - step * int'(bucket);
    return lvl[7:0];
  endfunction

endpackage

// File: rtl/tilt_shade_scheduler_rr_pick.sv
// Combinational round-robin pick: first set req bit after 'last', wrapping.
// Zero latency; any_req low means grant is meaningless.
module rr_pick #(
  parameter  int N_CH = 3,
  localparam int CW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0] req,
  input  logic [CW-1:0]   last,
  output logic [CW-1:0]   grant,
  output logic            any_req
);

  always_comb begin
    int idx;
    idx     = 0;
    grant   = '0;
    any_req = 1'b0;
    for (int off = 1; off <= N_CH; off++) begin
      idx = (int'(last) + off) % N_CH;
      if (!any_req && req[idx]) begin
        grant   = CW'(idx);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tilt_shade_scheduler.sv
// Round-robin shares one sequential z-bucket quantizer among N_CH tilt channels.
// Latency 2..8 cycles from req sample to color_valid; req waits while busy.
module tilt_shade_scheduler
  import tilt_shade_scheduler_pkg::*;
#(
  parameter  int N_CH       = 3,
  parameter  int Z_W        = 16,
  parameter  int MAX_Z      = DEF_MAX_Z,
  parameter  int SHADE_STEP = DEF_SHADE_STEP,
  localparam int CW         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [N_CH-1:0]     req,
  input  logic [N_CH*Z_W-1:0] z_in,
  output logic [N_CH-1:0]     ack,
  output logic [23:0]         color_out,
  output logic                color_valid,
  output logic [CW-1:0]       color_ch,
  output logic                busy
);

  localparam int BKT = MAX_Z / NUM_BUCKETS;

  state_t          state, state_nxt;
  logic [Z_W-1:0]  z_lat, z_sel, thr;
  logic [CW-1:0]   g, last, grant;
  logic [2:0]      k, bucket;
  logic [N_CH-1:0] ack_nxt;
  logic            any_req, hit, last_k;

  rr_pick #(.N_CH(N_CH)) u_pick (
    .req     (req),
    .last    (last),
    .grant   (grant),
    .any_req (any_req)
  );

  // One strict compare per cycle against k*b, walking from the darkest bucket down.
  always_comb begin
    thr    = Z_W'(int'(k) * BKT);
    hit    = z_lat > thr;
    last_k = (k == 3'd1);
    bucket = hit ? k : 3'd0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (any_req) state_nxt = ST_SEARCH;
      ST_SEARCH: if (hit || last_k) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != ST_IDLE);
    z_sel   = '0;
    ack_nxt = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant == CW'(i)) begin
        z_sel      = z_in[i*Z_W +: Z_W];
        ack_nxt[i] = any_req && (state == ST_IDLE);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      z_lat       <= '0;
      g           <= '0;
      last        <= CW'(N_CH - 1);
      k           <= 3'd7;
      ack         <= '0;
      color_out   <= 24'hFFFFFF;
      color_valid <= 1'b0;
      color_ch    <= '0;
    end else begin
      ack         <= ack_nxt;
      color_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            z_lat <= z_sel;
            g     <= grant;
            last  <= grant;
            k     <= 3'd7;
          end
        end
        ST_SEARCH: begin
          if (hit || last_k) begin
            color_out   <= {3{shade_of(bucket, SHADE_STEP)}};
            color_valid <= 1'b1;
            color_ch    <= g;
          end else begin
            k <= k - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/tilt_shade_scheduler.md
Name: tilt_shade_scheduler

Overview:
- Shares one sequential bucket-quantizer between N_CH tilt channels (pitch, roll, throttle) that each need a grayscale indicator color for the display overlay.
- A round-robin arbiter grants one channel at a time and latches its z sample.
- The quantizer walks thresholds 7*b down to 1*b, one compare per cycle, and emits a 24-bit gray color tagged with its channel.
- Downstream display logic keeps one color register per channel, written on color_valid.

Parameters:
N_CH, 3, number of requesting channels (2..8)
Z_W, 16, width of each unsigned z sample
MAX_Z, 300, full-scale z; bucket size b = MAX_Z/8 (integer divide, 37 at default)
SHADE_STEP, 25, gray decrement per bucket

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req  in  N_CH  per-channel request; held high until ack
z_in  in  N_CH*Z_W  packed z samples, channel i at bits [i*Z_W +: Z_W]
ack  out  N_CH  one-cycle grant pulse to the accepted channel
color_out  out  24  {R,G,B} gray result; holds its value between results
color_valid  out  1  one-cycle pulse when color_out/color_ch update
color_ch  out  clog2(N_CH)  channel index of the current color_out
busy  out  1  high in SEARCH and DONE

Behaviour:
- Reset (async assert, sync release) sets these values.
  - state=IDLE, ack=0, color_valid=0, busy=0, color_ch=0.
  - color_out=24'hFFFFFF.
  - Round-robin pointer last=N_CH-1, so channel 0 wins first.
- Reset mid-operation aborts to IDLE. No color_valid pulse; color_out returns to FFFFFF.
- States are IDLE, SEARCH and DONE.
- IDLE:
  - If any req bit is high, pick the first set bit scanning last+1, last+2, ... with wrap.
  - Latch z_in of the winner into z_lat. Register the winner as g and set last=g.
  - Pulse ack[g] on the next cycle. Enter SEARCH with k=7.
  - If no req is high, stay in IDLE.
- SEARCH (k counts 7 down to 1, one unsigned compare per cycle against the constant k*b at Z_W bits):
  - If z_lat > k*b, set bucket=k and go to DONE.
  - Else if k==1, set bucket=0 and go to DONE.
  - Else k=k-1.
- DONE (one cycle):
  - color_valid=1 and color_ch=g.
  - Each 8-bit channel of color_out = 255 if bucket==0, else 250 - SHADE_STEP*bucket (bucket 1 gives 225, bucket 7 gives 75).
  - Next state is IDLE.
- Latency with req sampled in IDLE at cycle T:
  - ack at T+1.
  - color_valid at T+9-bucket for bucket>=1, and at T+8 for bucket 0.
  - Minimum is 2 cycles; maximum is 8.
- Boundaries:
  - Comparison is strict. z == k*b falls into bucket k-1.
  - z=0 gives FFFFFF. z at its all-ones maximum gives 4B4B4B.
- Requester rules:
  - req is sampled only in IDLE. Requests arriving while busy wait; no request is lost while req stays high.
  - A req dropped before its ack is simply not serviced.
  - z_in must be stable in the sampling cycle. Later changes do not affect the in-flight result.
- Simultaneous requests are serviced in rotating order. No channel waits more than N_CH grants.
- ack is never asserted to more than one channel in the same cycle.

Decomposition:
- Shared package holds the following.
  - NUM_BUCKETS=8.
  - Default MAX_Z and SHADE_STEP.
  - State encoding.
  - Function shade_of(bucket) returning an 8-bit gray level, reused by pitch/roll color blocks.
- One sub-module, rr_pick: combinational, parameter N_CH.
  - Inputs: req and the last pointer.
  - Outputs: grant index and any_req.
- Scheduler FSM, z_lat, the k counter and output registers stay in tilt_shade_scheduler.

Test Plan:
- Reset: hold reset_n low, then release → color_out=FFFFFF, color_valid=0, ack=0, busy=0.
- Single channel, req[0] with z=300 at T → ack[0] at T+1, color_valid at T+2, color_out=4B4B4B, color_ch=0.
- Threshold sweep on channel 1, z = 37, 38, 74, 75, 259, 260 → colors FFFFFF, E1E1E1, E1E1E1, C8C8C8, 646464, 4B4B4B; verify each latency per the formula (z=37 valid at T+8).
- All three req high continuously with distinct z → grants in order 0, 1, 2, 0; each ack one cycle; each color_ch matches its z.
- req[2] raised while busy servicing channel 0 → ack[2] only after channel 0's color_valid; z_in[2] changed after its ack does not alter its color.
- reset_n pulsed low during SEARCH → no color_valid; next req to channel 0 is serviced as channel 0 first.
